conv_kxk_buffer_weights_multi: RTL and testbench

CONV_KXK_BUFFER_WEIGHTS_MULTI -- requirements
Module: conv_kxk_buffer_weights_multi

---
 rtl/conv_kxk_buffer_weights_multi.sv | 144 ++++++++++++++
 tb/tb_conv_kxk_buffer_weights_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/conv_kxk_buffer_weights_multi.sv
// Kernel weight buffer. Serial weight words are assembled into KERNEL_SIZE-tap
// kernels and stored in a DEPTH-entry ring. Kernels are read back either as a
// destructive FIFO pop or as a non-destructive circular replay.
module conv_kxk_buffer_weights_multi #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 9,
    parameter int DEPTH       = 256
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_in,
    input  logic [DATA_WIDTH-1:0]             in,
    output logic                              ready_in,
    input  logic                              load_weights,
    input  logic                              replay,
    input  logic                              clear,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] weight_out,
    output logic                              valid_out,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              empty,
    output logic                              full,
    output logic                              underflow
);

    localparam int KW = KERNEL_SIZE * DATA_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [AW-1:0] ASM_LAST = AW'(KERNEL_SIZE - 1);

    logic [KW-1:0] mem_q [DEPTH];

    logic [KW-1:0] asm_q, asm_d;
    logic [AW-1:0] asm_cnt_q, asm_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] cur_q, cur_d;
    logic [CW-1:0] count_q, count_d;
    logic [KW-1:0] wout_q, wout_d;
    logic          valid_q, valid_d;
    logic          uflow_q, uflow_d;

    logic          accept, commit, ld_ok, pop;
    logic [KW-1:0] kern;

    // Only the word that would complete a kernel is stalled by a full store.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign ready_in  = !(full && asm_cnt_q == ASM_LAST);
    assign count     = count_q;
    assign weight_out = wout_q;
    assign valid_out = valid_q;
    assign underflow = uflow_q;

    // Next-state: assembly, commit, pop/replay read, cursor and flags; clear wins.
    always_comb begin
        accept = valid_in && ready_in;
        commit = accept && (asm_cnt_q == ASM_LAST);
        ld_ok  = load_weights && (count_q != '0);
        pop    = ld_ok && !replay;

        kern = asm_q;
        kern[int'(asm_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in;

        asm_d     = asm_q;
        asm_cnt_d = asm_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cur_d     = cur_q;
        count_d   = count_q;
        wout_d    = wout_q;
        valid_d   = 1'b0;
        uflow_d   = uflow_q;

        if (accept) begin
            asm_d     = kern;
            asm_cnt_d = commit ? '0 : asm_cnt_q + AW'(1);
        end
        if (commit) wr_ptr_d = wr_ptr_q + PW'(1);

        // The read uses pre-edge memory contents, so a same-cycle commit never
        // bypasses into the output.
        if (ld_ok) begin
            valid_d = 1'b1;
            wout_d  = replay ? mem_q[cur_q] : mem_q[rd_ptr_q];
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

        if (commit && !pop)      count_d = count_q + CW'(1);
        else if (pop && !commit) count_d = count_q - CW'(1);

        if (load_weights && count_q == '0) uflow_d = 1'b1;

        // Outside replay the cursor follows the oldest entry, which also gives
        // the snap-to-oldest on a replay 1->0 transition.
        if (!replay) begin
            cur_d = rd_ptr_d;
        end else if (ld_ok) begin
            cur_d = (cur_q + PW'(1) == wr_ptr_q) ? rd_ptr_q : cur_q + PW'(1);
        end

        if (clear) begin
            asm_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cur_d     = '0;
            count_d   = '0;
            wout_d    = wout_q;
            valid_d   = 1'b0;
            uflow_d   = 1'b0;
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q     <= '0;
            asm_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cur_q     <= '0;
            count_q   <= '0;
            wout_q    <= '0;
            valid_q   <= 1'b0;
            uflow_q   <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            asm_cnt_q <= asm_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cur_q     <= cur_d;
            count_q   <= count_d;
            wout_q    <= wout_d;
            valid_q   <= valid_d;
            uflow_q   <= uflow_d;
        end
    end

    // Kernel store write; left unreset since pointers define what is valid.
    always_ff @(posedge clk) begin
        if (commit && !clear) mem_q[wr_ptr_q] <= kern;
    end

endmodule

// File: tb/tb_conv_kxk_buffer_weights_multi.sv
// Directed self-checking bench for conv_kxk_buffer_weights_multi (DEPTH=4).
module tb_conv_kxk_buffer_weights_multi;

    localparam int DW = 16;
    localparam int K  = 9;
    localparam int D  = 4;
    localparam int KW = K * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] in = '0;
    logic          ready_in;
    logic          load_weights = 1'b0;
    logic          replay = 1'b0;
    logic          clear = 1'b0;
    logic [KW-1:0] weight_out;
    logic          valid_out;
    logic [2:0]    count;
    logic          empty, full, underflow;

    int checks = 0;
    int errors = 0;

    conv_kxk_buffer_weights_multi #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .in(in), .ready_in(ready_in),
        .load_weights(load_weights), .replay(replay), .clear(clear),
        .weight_out(weight_out), .valid_out(valid_out), .count(count),
        .empty(empty), .full(full), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [KW-1:0] exp_k(input logic [DW-1:0] base);
        logic [KW-1:0] v;
        for (int k = 0; k < K; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            in = base + DW'(i);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic load(input logic rep);
        load_weights = 1'b1;
        replay = rep;
        @(posedge clk); #1;
        load_weights = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b0;
        #1;
        chk("rst_count", KW'(count), KW'(0));
        chk("rst_empty", KW'(empty), KW'(1));
        chk("rst_full", KW'(full), KW'(0));
        chk("rst_ready", KW'(ready_in), KW'(1));
        chk("rst_wout", weight_out, '0);
        chk("rst_valid", KW'(valid_out), KW'(0));
        chk("rst_uflow", KW'(underflow), KW'(0));
        @(negedge clk) reset = 1'b1;
        idle();

        // Basic load
        feed(16'd1, 9);
        chk("basic_count1", KW'(count), KW'(1));
        chk("basic_nempty", KW'(empty), KW'(0));
        load(1'b0);
        chk("basic_valid", KW'(valid_out), KW'(1));
        chk("basic_wout", weight_out, exp_k(16'd1));
        chk("basic_count0", KW'(count), KW'(0));
        idle();
        chk("basic_pulse", KW'(valid_out), KW'(0));
        chk("basic_hold", weight_out, exp_k(16'd1));

        // Underflow, then clear
        load(1'b0);
        chk("uf_valid", KW'(valid_out), KW'(0));
        chk("uf_wout", weight_out, exp_k(16'd1));
        chk("uf_flag", KW'(underflow), KW'(1));
        idle();
        chk("uf_sticky", KW'(underflow), KW'(1));
        clear = 1'b1; idle(); clear = 1'b0;
        chk("uf_clear", KW'(underflow), KW'(0));
        chk("clr_wout", weight_out, exp_k(16'd1));

        // Commit and pop in the same cycle
        feed(16'h100, 9);
        feed(16'h200, 8);
        valid_in = 1'b1; in = 16'h208; load_weights = 1'b1; replay = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0; load_weights = 1'b0;
        chk("sim_valid", KW'(valid_out), KW'(1));
        chk("sim_wout", weight_out, exp_k(16'h100));
        chk("sim_count", KW'(count), KW'(1));
        load(1'b0);
        chk("sim_wout2", weight_out, exp_k(16'h200));
        chk("sim_count0", KW'(count), KW'(0));

        // Full store: only the completing word stalls
        feed(16'h10, 9); feed(16'h20, 9); feed(16'h30, 9); feed(16'h40, 9);
        chk("full_count", KW'(count), KW'(4));
        chk("full_flag", KW'(full), KW'(1));
        chk("full_ready_part", KW'(ready_in), KW'(1));
        feed(16'h50, 8);
        chk("full_ready_stall", KW'(ready_in), KW'(0));
        valid_in = 1'b1; in = 16'h58;
        idle();
        chk("full_stall_count", KW'(count), KW'(4));
        chk("full_stall_ready", KW'(ready_in), KW'(0));
        load(1'b0);
        chk("full_pop", weight_out, exp_k(16'h10));
        chk("full_pop_count", KW'(count), KW'(3));
        chk("full_ready_back", KW'(ready_in), KW'(1));
        idle();
        valid_in = 1'b0;
        chk("full_recommit", KW'(count), KW'(4));
        load(1'b0); chk("drain0", weight_out, exp_k(16'h20));
        load(1'b0); chk("drain1", weight_out, exp_k(16'h30));
        load(1'b0); chk("drain2", weight_out, exp_k(16'h40));
        load(1'b0); chk("drain3", weight_out, exp_k(16'h50));
        chk("drain_empty", KW'(empty), KW'(1));

        // Replay: A,B,A,B,A then FIFO pop returns A
        feed(16'hA00, 9);
        feed(16'hB00, 9);
        load(1'b1); chk("rep0", weight_out, exp_k(16'hA00));
        load(1'b1); chk("rep1", weight_out, exp_k(16'hB00));
        load(1'b1); chk("rep2", weight_out, exp_k(16'hA00));
        load(1'b1); chk("rep3", weight_out, exp_k(16'hB00));
        load(1'b1); chk("rep4", weight_out, exp_k(16'hA00));
        chk("rep_count", KW'(count), KW'(2));
        chk("rep_valid", KW'(valid_out), KW'(1));
        load(1'b0);
        chk("rep_fifo", weight_out, exp_k(16'hA00));
        chk("rep_fifo_count", KW'(count), KW'(1));
        load(1'b0);
        chk("rep_fifo2", weight_out, exp_k(16'hB00));

        // Clear mid-assembly discards the partial kernel
        feed(16'hE00, 3);
        clear = 1'b1; idle(); clear = 1'b0;
        feed(16'hF00, 9);
        load(1'b0);
        chk("clr_asm", weight_out, exp_k(16'hF00));

        // Reset mid-assembly discards the partial kernel
        feed(16'hC00, 5);
        #2 reset = 1'b0;
        #1;
        chk("rst2_count", KW'(count), KW'(0));
        chk("rst2_wout", weight_out, '0);
        @(negedge clk) reset = 1'b1;
        idle();
        feed(16'hD00, 9);
        chk("rst2_count1", KW'(count), KW'(1));
        load(1'b0);
        chk("rst2_kernel", weight_out, exp_k(16'hD00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
